uart_fifo_ext: RTL and testbench

Parametrised synchronous FIFO for the UART TX/RX paths. It generalises depth and width, and adds:
- a selectable read mode: registered or first-word-fall-through (FWFT)
- an occupancy count
- programmable almost-full and almost-empty flags
- sticky overflow and underflow error flags
- a synchronous flush
It sits between the UART byte engines and the host/bus side, with one clock domain.

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_fifo_mem.sv | 20 ++
 rtl/uart_fifo_ext.sv | 92 +++++++++
 tb/tb_uart_fifo_ext.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART word/FIFO sizing constants and the FIFO address-width helper.
package uart_pkg;
  localparam int UART_WORD_W = 8;
  localparam int UART_FIFO_DEPTH = 16;
  function automatic int uart_aw(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: WIDTH x DEPTH storage, one synchronous write port, one combinational read port.
//   clk            rising-edge clock
//   we/waddr/wdata write enable, address, data
//   raddr/rdata    combinational read address and data
module uart_fifo_mem import uart_pkg::*; #(
  parameter int WIDTH = UART_WORD_W,
  parameter int DEPTH = UART_FIFO_DEPTH,
  localparam int AW = uart_aw(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/uart_fifo_ext.sv
// uart_fifo_ext: synchronous UART FIFO with registered/FWFT read, occupancy, almost flags, sticky errors, flush.
//   clk, rst (async, active-low)
//   datain/wr       write data and request
//   rd              pop request
//   flush           synchronous clear of contents
//   clr_err         clears overflow/underflow
//   dataout         read data
//   full/empty/almost_full/almost_empty/count  occupancy status (from registered pointers)
//   overflow/underflow                          sticky rejected-write / rejected-read flags
module uart_fifo_ext import uart_pkg::*; #(
  parameter int WIDTH = UART_WORD_W,
  parameter int DEPTH = UART_FIFO_DEPTH,
  parameter bit FWFT = 1'b0,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 1,
  localparam int AW = uart_aw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] datain,
  input  logic             wr,
  input  logic             rd,
  input  logic             flush,
  input  logic             clr_err,
  output logic [WIDTH-1:0] dataout,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_fifo_ext: DEPTH must be a power of two >= 2");
  end
  if (AF_LEVEL > DEPTH) begin : g_bad_af
    $error("uart_fifo_ext: AF_LEVEL must not exceed DEPTH");
  end
  if (AE_LEVEL >= DEPTH) begin : g_bad_ae
    $error("uart_fifo_ext: AE_LEVEL must be below DEPTH");
  end
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_C = (AW+1)'(AE_LEVEL);
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic ovf_q, ovf_d, udf_q, udf_d;
  logic [WIDTH-1:0] dout_q, dout_d, rdata;
  logic wr_ok, rd_ok;
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count = wp_q - rp_q;
  assign full = count == DEPTH_C;
  assign empty = count == '0;
  assign almost_full = count >= AF_C;
  assign almost_empty = count <= AE_C;
  assign overflow = ovf_q;
  assign underflow = udf_q;
  assign dataout = FWFT ? (empty ? '0 : rdata) : dout_q;
  always_comb begin
    wr_ok = wr & ~full & ~flush;
    rd_ok = rd & ~empty & ~flush;
    wp_d = flush ? '0 : wp_q + {{AW{1'b0}}, wr_ok};
    rp_d = flush ? '0 : rp_q + {{AW{1'b0}}, rd_ok};
    // Set terms listed first so a new error wins over a same-cycle clear.
    ovf_d = (wr & full & ~flush) | (ovf_q & ~clr_err);
    udf_d = (rd & empty & ~flush) | (udf_q & ~clr_err);
    dout_d = rd_ok ? rdata : dout_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q <= '0;
      rp_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
      dout_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
      dout_q <= dout_d;
    end
  end
  uart_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .we(wr_ok),
    .waddr(wp_q[AW-1:0]),
    .wdata(datain),
    .raddr(rp_q[AW-1:0]),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_uart_fifo_ext.sv
// tb_uart_fifo_ext: drives a registered-read and an FWFT instance with identical stimulus against a queue model.
module tb_uart_fifo_ext;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] datain = 8'h00;
  logic wr = 1'b0, rd = 1'b0, flush = 1'b0, clr_err = 1'b0;
  logic [7:0] a_dout, b_dout;
  logic [4:0] a_count, b_count;
  logic a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
  logic b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
  logic [18:0] obs_a, obs_b;
  logic [7:0] q [$];
  logic m_ovf = 1'b0, m_udf = 1'b0;
  logic [7:0] m_dout = 8'h00;
  int n_chk = 0, n_pass = 0;
  localparam logic [18:0] RST_VEC = {5'd0, 6'b100100, 8'h00};
  always #5 clk = ~clk;
  uart_fifo_ext #(.FWFT(1'b0)) dut_a (
    .clk(clk), .rst(rst), .datain(datain), .wr(wr), .rd(rd), .flush(flush), .clr_err(clr_err),
    .dataout(a_dout), .full(a_full), .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae),
    .count(a_count), .overflow(a_ovf), .underflow(a_udf)
  );
  uart_fifo_ext #(.FWFT(1'b1)) dut_b (
    .clk(clk), .rst(rst), .datain(datain), .wr(wr), .rd(rd), .flush(flush), .clr_err(clr_err),
    .dataout(b_dout), .full(b_full), .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
    .count(b_count), .overflow(b_ovf), .underflow(b_udf)
  );
  assign obs_a = {a_count, a_empty, a_full, a_af, a_ae, a_ovf, a_udf, a_dout};
  assign obs_b = {b_count, b_empty, b_full, b_af, b_ae, b_ovf, b_udf, b_dout};
  function automatic logic [18:0] model_vec(input bit fwft);
    int n;
    logic [7:0] d;
    n = q.size();
    d = fwft ? (n == 0 ? 8'h00 : q[0]) : m_dout;
    return {5'(n), n == 0, n == 16, n >= 14, n <= 1, m_ovf, m_udf, d};
  endfunction
  task automatic cyc(input logic w, input logic r, input logic f, input logic c, input logic [7:0] d);
    int n0;
    wr = w; rd = r; flush = f; clr_err = c; datain = d;
    @(posedge clk);
    n0 = q.size();
    m_ovf = (!f && w && n0 == 16) || (m_ovf && !c);
    m_udf = (!f && r && n0 == 0) || (m_udf && !c);
    if (f) q.delete();
    else begin
      if (r && n0 != 0) m_dout = q.pop_front();
      if (w && n0 != 16) q.push_back(d);
    end
    #1;
    wr = 1'b0; rd = 1'b0; flush = 1'b0; clr_err = 1'b0;
  endtask
  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0; m_udf = 1'b0; m_dout = 8'h00;
  endtask
  task automatic test_reset();
    #12;
    n_chk++; if (obs_a !== RST_VEC) $display("FAIL reset_a got %h exp %h", obs_a, RST_VEC); else n_pass++;
    n_chk++; if (obs_b !== RST_VEC) $display("FAIL reset_b got %h exp %h", obs_b, RST_VEC); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
  endtask
  task automatic test_fwft();
    cyc(1, 0, 0, 0, 8'h5A);
    n_chk++; if ({b_dout, b_empty} !== {8'h5A, 1'b0}) $display("FAIL fwft_write got %h/%b exp 5a/0", b_dout, b_empty); else n_pass++;
    cyc(0, 1, 0, 0, 8'h00);
    n_chk++; if ({b_dout, b_empty} !== {8'h00, 1'b1}) $display("FAIL fwft_pop got %h/%b exp 00/1", b_dout, b_empty); else n_pass++;
    n_chk++; if (a_dout !== 8'h5A) $display("FAIL reg_pop got %h exp 5a", a_dout); else n_pass++;
  endtask
  task automatic test_fill_drain();
    for (int i = 1; i <= 16; i++) begin
      cyc(1, 0, 0, 0, 8'(i));
      n_chk++; if ({a_count, a_af} !== {5'(i), i >= 14}) $display("FAIL fill_cnt[%0d] got %0d/%b", i, a_count, a_af); else n_pass++;
      n_chk++; if (obs_b !== model_vec(1)) $display("FAIL fill_b[%0d] got %h exp %h", i, obs_b, model_vec(1)); else n_pass++;
    end
    n_chk++; if (a_full !== 1'b1) $display("FAIL full got %b exp 1", a_full); else n_pass++;
    cyc(1, 0, 0, 0, 8'hAA);
    n_chk++; if ({a_count, a_ovf, b_ovf} !== {5'd16, 2'b11}) $display("FAIL overflow got %0d/%b/%b exp 16/1/1", a_count, a_ovf, b_ovf); else n_pass++;
    for (int i = 1; i <= 16; i++) begin
      cyc(0, 1, 0, 0, 8'h00);
      n_chk++; if (a_dout !== 8'(i)) $display("FAIL drain[%0d] got %h exp %h", i, a_dout, 8'(i)); else n_pass++;
      n_chk++; if (obs_b !== model_vec(1)) $display("FAIL drain_b[%0d] got %h exp %h", i, obs_b, model_vec(1)); else n_pass++;
    end
    n_chk++; if ({a_empty, b_empty} !== 2'b11) $display("FAIL drained_empty got %b%b exp 11", a_empty, b_empty); else n_pass++;
  endtask
  task automatic test_underflow();
    cyc(0, 1, 0, 0, 8'h00);
    n_chk++; if ({a_udf, a_dout, a_count} !== {1'b1, 8'h10, 5'd0}) $display("FAIL underflow got %b/%h/%0d exp 1/10/0", a_udf, a_dout, a_count); else n_pass++;
    cyc(0, 0, 0, 1, 8'h00);
    n_chk++; if ({a_udf, a_ovf} !== 2'b00) $display("FAIL clr_err got %b%b exp 00", a_udf, a_ovf); else n_pass++;
    cyc(0, 1, 0, 1, 8'h00);
    n_chk++; if ({a_udf, b_udf} !== 2'b11) $display("FAIL set_wins got %b%b exp 11", a_udf, b_udf); else n_pass++;
    cyc(0, 0, 0, 1, 8'h00);
    n_chk++; if (obs_a !== model_vec(0)) $display("FAIL uf_clear got %h exp %h", obs_a, model_vec(0)); else n_pass++;
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 8'h80 + 8'(i));
    for (int i = 0; i < 40; i++) begin
      cyc(1, 1, 0, 0, 8'h88 + 8'(i));
      n_chk++; if ({a_count, a_dout} !== {5'd8, 8'h80 + 8'(i)}) $display("FAIL b2b[%0d] got %0d/%h exp 8/%h", i, a_count, a_dout, 8'h80 + 8'(i)); else n_pass++;
      n_chk++; if (obs_b !== model_vec(1)) $display("FAIL b2b_b[%0d] got %h exp %h", i, obs_b, model_vec(1)); else n_pass++;
    end
  endtask
  task automatic test_flush();
    cyc(0, 0, 1, 0, 8'h00);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 8'h40 + 8'(i));
    n_chk++; if (a_count !== 5'd5) $display("FAIL pre_flush got %0d exp 5", a_count); else n_pass++;
    cyc(1, 0, 1, 0, 8'h77);
    n_chk++; if ({a_count, a_empty, a_dout} !== {5'd0, 1'b1, 8'hA7}) $display("FAIL flush got %0d/%b/%h exp 0/1/a7", a_count, a_empty, a_dout); else n_pass++;
    cyc(1, 0, 0, 0, 8'h33);
    n_chk++; if (b_dout !== 8'h33) $display("FAIL flush_fwft got %h exp 33", b_dout); else n_pass++;
    cyc(0, 1, 0, 0, 8'h00);
    n_chk++; if ({a_dout, a_empty} !== {8'h33, 1'b1}) $display("FAIL flush_read got %h/%b exp 33/1", a_dout, a_empty); else n_pass++;
  endtask
  task automatic test_async_reset();
    cyc(1, 0, 0, 0, 8'h11);
    cyc(0, 1, 0, 0, 8'h00);
    cyc(0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 9; i++) cyc(1, 0, 0, 0, 8'h60 + 8'(i));
    n_chk++; if (a_count !== 5'd9 || a_udf !== 1'b1) $display("FAIL pre_reset got %0d/%b exp 9/1", a_count, a_udf); else n_pass++;
    #2 rst = 1'b0;
    #1;
    model_reset();
    n_chk++; if (obs_a !== RST_VEC) $display("FAIL async_rst_a got %h exp %h", obs_a, RST_VEC); else n_pass++;
    n_chk++; if (obs_b !== RST_VEC) $display("FAIL async_rst_b got %h exp %h", obs_b, RST_VEC); else n_pass++;
    @(posedge clk);
    #1 rst = 1'b1;
    cyc(1, 0, 0, 0, 8'h21);
    cyc(0, 1, 0, 0, 8'h00);
    n_chk++; if ({a_dout, a_empty} !== {8'h21, 1'b1}) $display("FAIL post_reset got %h/%b exp 21/1", a_dout, a_empty); else n_pass++;
  endtask
  task automatic test_random();
    logic w, r, f, c;
    for (int i = 0; i < 600; i++) begin
      w = (i % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      r = (i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      f = $urandom_range(0, 59) == 0;
      c = !f && $urandom_range(0, 15) == 0;
      cyc(w, r, f, c, 8'($urandom));
      n_chk++; if (obs_a !== model_vec(0)) $display("FAIL rand_a[%0d] got %h exp %h", i, obs_a, model_vec(0)); else n_pass++;
      n_chk++; if (obs_b !== model_vec(1)) $display("FAIL rand_b[%0d] got %h exp %h", i, obs_b, model_vec(1)); else n_pass++;
    end
  endtask
  initial begin
    test_reset();
    test_fwft();
    test_fill_drain();
    test_underflow();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
